// File: rtl/rx_link_fault_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_link_fault_monitor_if : XGMII receive stream in, registered       |
// | stream plus link fault status out.   Rev 1.0                         |
// +----------------------------------------------------------------------+
interface rx_link_fault_monitor_if;
    logic [63:0] rxd64_in;
    logic [7:0]  rxc8_in;
    logic [63:0] rxd64;
    logic [7:0]  rxc8;
    logic [1:0]  link_fault;
    logic        seq_detect;

    modport master (
        output rxd64_in, rxc8_in,
        input  rxd64, rxc8, link_fault, seq_detect
    );

    modport slave (
        input  rxd64_in, rxc8_in,
        output rxd64, rxc8, link_fault, seq_detect
    );
endinterface
`default_nettype wire

// File: rtl/rx_link_fault_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_link_fault_monitor : detects XGMII fault ordered sets and runs    |
// | the link fault state machine.   Rev 1.0                              |
// +----------------------------------------------------------------------+
module rx_link_fault_monitor #(
    parameter int COL_WINDOW = 128,
    parameter int SEQ_THRESH = 4,
    parameter int CNT_W      = 8
) (
    input  wire logic              rxclk,
    input  wire logic              reset,
    rx_link_fault_monitor_if.slave bus
);
    localparam int SEQ_W = $clog2(SEQ_THRESH + 1);
    localparam logic [CNT_W-1:0] C_WINDOW = CNT_W'(COL_WINDOW);
    localparam logic [SEQ_W-1:0] C_THRESH = SEQ_W'(SEQ_THRESH);
    localparam logic [SEQ_W-1:0] C_ONE    = SEQ_W'(1);

    typedef enum logic [1:0] {SEQ_NONE, SEQ_LOCAL, SEQ_REMOTE} seq_type_t;
    // State encoding doubles as the link_fault output value.
    typedef enum logic [1:0] {ST_OK = 2'b00, ST_LOCAL = 2'b10, ST_REMOTE = 2'b11} state_t;

    state_t            r_state, w_state;
    seq_type_t         r_seq_type, w_seq_type, w_col_kind;
    logic [CNT_W-1:0]  r_col_cnt, w_col_cnt;
    logic [SEQ_W-1:0]  r_seq_cnt, w_seq_cnt;
    logic              w_seq_any;
    logic [63:0]       r_rxd64;
    logic [7:0]        r_rxc8;
    logic              r_seq_detect;

    function automatic seq_type_t decode_col(input logic [31:0] d, input logic [3:0] k);
        seq_type_t t;
        t = SEQ_NONE;
        if (k == 4'b0001 && d[7:0] == 8'h9C && d[15:8] == 8'h00 && d[23:16] == 8'h00) begin
            if (d[31:24] == 8'h01)
                t = SEQ_LOCAL;
            else if (d[31:24] == 8'h02)
                t = SEQ_REMOTE;
        end
        return t;
    endfunction

    // Column A then column B, each step seeing the result of the previous one.
    always_comb begin
        w_state    = r_state;
        w_seq_type = r_seq_type;
        w_col_cnt  = r_col_cnt;
        w_seq_cnt  = r_seq_cnt;
        w_col_kind = SEQ_NONE;
        w_seq_any  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            w_col_kind = decode_col(bus.rxd64_in[32*c +: 32], bus.rxc8_in[4*c +: 4]);
            if (w_col_kind == SEQ_NONE) begin
                if (w_col_cnt < C_WINDOW)
                    w_col_cnt = w_col_cnt + 1'b1;
                if (w_state != ST_OK && w_col_cnt == C_WINDOW) begin
                    w_state   = ST_OK;
                    w_seq_cnt = '0;
                end
            end else begin
                w_seq_any = 1'b1;
                if (w_col_kind != w_seq_type || w_col_cnt >= C_WINDOW) begin
                    w_seq_type = w_col_kind;
                    w_seq_cnt  = C_ONE;
                end else if (w_seq_cnt < C_THRESH) begin
                    w_seq_cnt = w_seq_cnt + 1'b1;
                end
                w_col_cnt = '0;
                if (w_seq_cnt == C_THRESH)
                    w_state = (w_col_kind == SEQ_LOCAL) ? ST_LOCAL : ST_REMOTE;
            end
        end
    end

    always_ff @(posedge rxclk) begin
        if (!reset) begin
            r_state      <= ST_OK;
            r_seq_type   <= SEQ_NONE;
            r_col_cnt    <= '0;
            r_seq_cnt    <= '0;
            r_rxd64      <= 64'h0707070707070707;
            r_rxc8       <= 8'hFF;
            r_seq_detect <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_seq_type   <= w_seq_type;
            r_col_cnt    <= w_col_cnt;
            r_seq_cnt    <= w_seq_cnt;
            r_rxd64      <= bus.rxd64_in;
            r_rxc8       <= bus.rxc8_in;
            r_seq_detect <= w_seq_any;
        end
    end

    assign bus.rxd64      = r_rxd64;
    assign bus.rxc8       = r_rxc8;
    assign bus.link_fault = r_state;
    assign bus.seq_detect = r_seq_detect;
endmodule
`default_nettype wire

// File: tb/tb_rx_link_fault_monitor.sv
`default_nettype none
// Directed self-checking bench for rx_link_fault_monitor.
module tb_rx_link_fault_monitor;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_asserts = 0;
    int   n_fail    = 0;

    localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
    localparam logic [7:0]  IDLE_C  = 8'hFF;
    localparam logic [63:0] LOC_A_D = {32'h07070707, 32'h0100009C};
    localparam logic [63:0] REM_A_D = {32'h07070707, 32'h0200009C};
    localparam logic [63:0] REM_2_D = {32'h0200009C, 32'h0200009C};
    localparam logic [63:0] BAD_D   = {32'h07070707, 32'h0105009C};
    localparam logic [7:0]  SEQ_A_C = 8'hF1;
    localparam logic [7:0]  SEQ_2_C = 8'h11;

    rx_link_fault_monitor_if bus();

    rx_link_fault_monitor dut (
        .rxclk (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [63:0] d, input logic [7:0] k);
        bus.rxd64_in = d;
        bus.rxc8_in  = k;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] rd;
        logic [7:0]  rk;

        // Reset with idle input
        drive(IDLE_D, IDLE_C);
        drive(IDLE_D, IDLE_C);
        check("rst_rxd64", bus.rxd64, IDLE_D);
        check("rst_rxc8", {56'b0, bus.rxc8}, {56'b0, IDLE_C});
        check("rst_lf", {62'b0, bus.link_fault}, 64'd0);
        check("rst_sd", {63'b0, bus.seq_detect}, 64'd0);
        reset = 1'b1;

        // Four local sequences in column A declare a local fault
        for (int i = 1; i <= 4; i++) begin
            drive(LOC_A_D, SEQ_A_C);
            check("loc_sd", {63'b0, bus.seq_detect}, 64'd1);
            check("loc_lf", {62'b0, bus.link_fault}, (i == 4) ? 64'd2 : 64'd0);
        end
        // 64 idle words: clears exactly on the 64th
        for (int i = 1; i <= 64; i++) begin
            drive(IDLE_D, IDLE_C);
            if (i == 1)  check("idle_sd", {63'b0, bus.seq_detect}, 64'd0);
            if (i == 63) check("idle63_lf", {62'b0, bus.link_fault}, 64'd2);
            if (i == 64) check("idle64_lf", {62'b0, bus.link_fault}, 64'd0);
        end

        // Remote in both columns, two words
        drive(REM_2_D, SEQ_2_C);
        check("rem1_lf", {62'b0, bus.link_fault}, 64'd0);
        drive(REM_2_D, SEQ_2_C);
        check("rem2_lf", {62'b0, bus.link_fault}, 64'd3);
        // Remote sequences spaced 63 idle words apart keep the fault
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 63; i++) drive(IDLE_D, IDLE_C);
            check("gap63_idle_lf", {62'b0, bus.link_fault}, 64'd3);
            drive(REM_A_D, SEQ_A_C);
            check("gap63_seq_lf", {62'b0, bus.link_fault}, 64'd3);
        end
        // 65 idle words: clears on the 64th
        for (int i = 1; i <= 65; i++) begin
            drive(IDLE_D, IDLE_C);
            if (i == 63) check("gap65_63_lf", {62'b0, bus.link_fault}, 64'd3);
            if (i == 64) check("gap65_64_lf", {62'b0, bus.link_fault}, 64'd0);
            if (i == 65) check("gap65_65_lf", {62'b0, bus.link_fault}, 64'd0);
        end

        // Alternating types never build a count
        for (int i = 0; i < 8; i++) begin
            drive((i % 2 == 0) ? LOC_A_D : REM_A_D, SEQ_A_C);
            check("alt_sd", {63'b0, bus.seq_detect}, 64'd1);
            check("alt_lf", {62'b0, bus.link_fault}, 64'd0);
        end

        // Corrupted sequences count as ordinary columns
        for (int i = 0; i < 10; i++) begin
            drive(BAD_D, SEQ_A_C);
            check("bad_sd", {63'b0, bus.seq_detect}, 64'd0);
            check("bad_lf", {62'b0, bus.link_fault}, 64'd0);
        end
        check("bad_rxd64", bus.rxd64, BAD_D);

        // Random data forwarded with one cycle delay
        for (int i = 0; i < 8; i++) begin
            rd = {$urandom, $urandom};
            rk = 8'($urandom);
            drive(rd, rk);
            check("rnd_rxd64", bus.rxd64, rd);
            check("rnd_rxc8", {56'b0, bus.rxc8}, {56'b0, rk});
        end
        for (int i = 0; i < 70; i++) drive(IDLE_D, IDLE_C);
        check("pre_lf", {62'b0, bus.link_fault}, 64'd0);

        // Reset mid-fault, then re-declare only after four new sequences
        for (int i = 0; i < 4; i++) drive(LOC_A_D, SEQ_A_C);
        check("pre_rst_lf", {62'b0, bus.link_fault}, 64'd2);
        reset = 1'b0;
        drive(LOC_A_D, SEQ_A_C);
        check("midrst_lf", {62'b0, bus.link_fault}, 64'd0);
        check("midrst_sd", {63'b0, bus.seq_detect}, 64'd0);
        check("midrst_rxd64", bus.rxd64, IDLE_D);
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(LOC_A_D, SEQ_A_C);
            check("post_rst_lf", {62'b0, bus.link_fault}, (i == 4) ? 64'd2 : 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rx_link_fault_monitor.md
Name: rx_link_fault_monitor

Overview:
- Receive-side reconciliation stage that sits directly upstream of the receive engine and drives its `link_fault[1:0]` input.
- Scans the 64-bit XGMII receive stream, two 32-bit columns per cycle, for local/remote fault Sequence ordered sets.
- Runs the 802.3 clause-46 style link fault state machine.
- Forwards `rxd64`/`rxc8` to the engine with one register stage, so data and fault status stay aligned.

Parameters:
- COL_WINDOW, 128, columns without a fault sequence that clear a fault or restart the sequence count.
- SEQ_THRESH, 4, consecutive same-type sequences (each within COL_WINDOW of the previous) needed to declare a fault.
- CNT_W, 8, width of the column counter; must satisfy 2^CNT_W > COL_WINDOW.

Ports:
- rxclk  in  1  receive clock; the only clock.
- reset  in  1  synchronous, active-low reset.
- rxd64_in  in  64  XGMII data; lane0 = [7:0] … lane7 = [63:56].
- rxc8_in  in  8  XGMII control; bit i qualifies lane i.
- rxd64  out  64  registered copy of rxd64_in (to receive engine).
- rxc8  out  8  registered copy of rxc8_in.
- link_fault  out  2  00 = OK, 10 = local fault, 11 = remote fault.
- seq_detect  out  1  one-cycle pulse: at least one valid fault sequence was in the word registered this cycle.

Behaviour:
- Interface: one clock (`rxclk`); `reset` is synchronous and active-low.
- Reset (reset = 0 at a rxclk edge):
  - rxd64 = 64'h0707070707070707, rxc8 = 8'hFF (idle).
  - link_fault = 00, seq_detect = 0.
  - Internal: col_cnt = 0, seq_cnt = 0, seq_type = NONE.
  - Reset asserted mid-fault returns to OK immediately; there is no hysteresis.
- Column decode (col A = lanes 0-3 / bits 31:0, col B = lanes 4-7 / bits 63:32):
  - A column is a fault sequence iff its ctrl nibble = 4'b0001, byte0 = 8'h9C, byte1 = 8'h00, byte2 = 8'h00, and byte3 = 8'h01 (LOCAL) or 8'h02 (REMOTE).
  - Any other byte3 value, or any other ctrl pattern, is a non-sequence column.
  - The sequence may appear in col A, col B, or both.
- Per cycle, col A is processed first, then col B, as a combinational chain. All registers update once at the end of the cycle.
- For each non-sequence column: col_cnt = min(col_cnt+1, COL_WINDOW); saturates and never wraps.
- For each sequence column of type T:
  - If T != seq_type, or col_cnt >= COL_WINDOW: seq_type = T, seq_cnt = 1.
  - Otherwise: seq_cnt = min(seq_cnt+1, SEQ_THRESH).
  - col_cnt = 0 in both cases.
- State machine (held in link_fault):
  - OK → FAULT(T): when seq_cnt reaches SEQ_THRESH with seq_type = T.
  - FAULT(T) → FAULT(T'): when SEQ_THRESH sequences of a different type T' accumulate.
  - FAULT → OK: when col_cnt reaches COL_WINDOW (128 columns = 64 cycles with no sequence). seq_cnt is cleared on this transition.
- Encoding: LOCAL → 10, REMOTE → 11.
- Latency and alignment:
  - rxd64/rxc8 are delayed exactly 1 cycle.
  - link_fault and seq_detect update on the same edge that presents the word that caused the change, so they are aligned with that word on rxd64.
- Simultaneous events:
  - If col A completes the threshold and col B is a different-type sequence, col B restarts the count (seq_cnt = 1). link_fault takes col A's type this cycle, because reaching the threshold at any point in the chain sets FAULT.
  - If col A clears the fault and col B is a sequence, the final state is OK with seq_cnt = 1.
- Corrupt sequences (e.g. byte1 = 8'h01) count as ordinary columns.

Test Plan:
- Reset low 2 cycles, idle input → rxd64 = 0707…07, rxc8 = FF, link_fault = 00, seq_detect = 0.
- 4 words with col A = {8'h01,8'h00,8'h00,8'h9C}/ctrl 0001, rest idle → seq_detect pulses each word; link_fault = 10 on the 4th word's output cycle (one cycle after its input). Then 64 idle words → link_fault = 00 exactly on the 64th idle output cycle.
- 2 words with a remote sequence in both columns → link_fault = 11 after the 2nd word. 3 remote sequences spaced 63 idle words apart → stays 11. Spacing of 65 idle words → returns to 00.
- Alternate local/remote sequences, 8 words, one per word → seq_cnt never exceeds 1; link_fault stays 00.
- Corrupted sequence (byte2 = 8'h05), 10 words → seq_detect = 0, link_fault = 00. Random data words → rxd64/rxc8 equal the inputs delayed by exactly 1 cycle.
- While link_fault = 10, assert reset 1 cycle → next cycle link_fault = 00. Resume local sequences → fault is re-declared only after 4 new sequences.
